// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : RISC-V MEM stage. It runs loads and stores over a busywait
//               memory port and owns the MEM/WB pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_mem_r_in,
    input  logic        d_mem_w_in,
    input  logic [2:0]  fun_3_in,
    input  logic [31:0] address_in,
    input  logic [31:0] store_data_in,
    input  logic        mux_d_mem_in,
    input  logic        write_reg_en_in,
    input  logic [4:0]  write_address_in,
    output logic        mem_read,
    output logic        mem_write,
    output logic [29:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait,
    output logic        busywait,
    output logic        misalign_fault,
    output logic        timeout_fault,
    output logic [31:0] wb_data,
    output logic        wb_write_en,
    output logic [4:0]  wb_address
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_addr;
    logic [2:0]      r_fun3;
    logic            r_mux;
    logic            r_we;
    logic [4:0]      r_rd;
    logic [31:0]     r_load;

    logic            w_req;
    logic            w_illegal;
    logic            w_last;
    logic            w_abort;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_shift;
    logic [15:0]     w_half;
    logic [31:0]     w_load;

    assign w_req = d_mem_r_in | d_mem_w_in;

    always_comb begin
        w_illegal = 1'b0;
        case (fun_3_in)
            3'b000, 3'b100: w_illegal = 1'b0;
            3'b001, 3'b101: w_illegal = address_in[0];
            3'b010:         w_illegal = |address_in[1:0];
            default:        w_illegal = 1'b1;
        endcase
    end

    // The final ACCESS cycle aborts only if memory is still busy, so the
    // stall drops in that same cycle and EX/MEM can move past the bad access.
    assign w_last  = (r_cnt == CW'(TIMEOUT - 1));
    assign w_abort = (r_state == S_ACCESS) && w_last && mem_busywait;

    assign busywait       = !reset &&
                            (((r_state == S_IDLE) && w_req && !w_illegal) ||
                             ((r_state == S_ACCESS) && !w_abort));
    assign misalign_fault = !reset && (r_state == S_IDLE) && w_req && w_illegal;
    assign timeout_fault  = !reset && w_abort;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data_in;
        case (fun_3_in[1:0])
            2'b00: begin
                w_be    = 4'b0001 << address_in[1:0];
                w_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << address_in[1:0];
                w_wdata = {2{store_data_in[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data_in;
            end
        endcase
    end

    assign w_shift = mem_readdata >> {r_addr[1:0], 3'b000};
    assign w_half  = r_addr[1] ? mem_readdata[31:16] : mem_readdata[15:0];

    always_comb begin
        w_load = mem_readdata;
        case (r_fun3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_addr         <= '0;
            r_fun3         <= '0;
            r_mux          <= 1'b0;
            r_we           <= 1'b0;
            r_rd           <= '0;
            r_load         <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
            wb_data        <= '0;
            wb_write_en    <= 1'b0;
            wb_address     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_req) begin
                        wb_data     <= address_in;
                        wb_write_en <= write_reg_en_in;
                        wb_address  <= write_address_in;
                    end else if (w_illegal) begin
                        wb_write_en <= 1'b0;
                    end else begin
                        r_addr         <= address_in;
                        r_fun3         <= fun_3_in;
                        r_mux          <= mux_d_mem_in;
                        r_we           <= write_reg_en_in;
                        r_rd           <= write_address_in;
                        r_cnt          <= '0;
                        mem_read       <= d_mem_r_in;
                        mem_write      <= !d_mem_r_in;
                        mem_address    <= address_in[31:2];
                        mem_writedata  <= d_mem_r_in ? 32'd0 : w_wdata;
                        mem_byteenable <= d_mem_r_in ? 4'd0 : w_be;
                        // Bubble into WB while the access is outstanding
                        wb_write_en    <= 1'b0;
                        r_state        <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!mem_busywait) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        r_load    <= w_load;
                        r_state   <= S_COMPLETE;
                    end else if (w_last) begin
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        wb_write_en <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMPLETE: begin
                    wb_data     <= r_mux ? r_load : r_addr;
                    wb_write_en <= r_we;
                    wb_address  <= r_rd;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_mem_r_in, d_mem_w_in;
    logic [2:0]  fun_3_in;
    logic [31:0] address_in, store_data_in;
    logic        mux_d_mem_in, write_reg_en_in;
    logic [4:0]  write_address_in;
    logic        mem_read, mem_write;
    logic [29:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
    logic        busywait, misalign_fault, timeout_fault;
    logic [31:0] wb_data;
    logic        wb_write_en;
    logic [4:0]  wb_address;

    int n_checks = 0;
    int n_pass   = 0;

    // Values captured by do_access
    int          bw_cycles, strobe_cycles;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_rd, cap_wr, end_tf, end_mf;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .d_mem_r_in       (d_mem_r_in),
        .d_mem_w_in       (d_mem_w_in),
        .fun_3_in         (fun_3_in),
        .address_in       (address_in),
        .store_data_in    (store_data_in),
        .mux_d_mem_in     (mux_d_mem_in),
        .write_reg_en_in  (write_reg_en_in),
        .write_address_in (write_address_in),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_writedata    (mem_writedata),
        .mem_byteenable   (mem_byteenable),
        .mem_readdata     (mem_readdata),
        .mem_busywait     (mem_busywait),
        .busywait         (busywait),
        .misalign_fault   (misalign_fault),
        .timeout_fault    (timeout_fault),
        .wb_data          (wb_data),
        .wb_write_en      (wb_write_en),
        .wb_address       (wb_address)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic set_op(input logic r, input logic w, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic mux, input logic we, input logic [4:0] rd);
        d_mem_r_in = r; d_mem_w_in = w; fun_3_in = f3; address_in = addr;
        store_data_in = sd; mux_d_mem_in = mux; write_reg_en_in = we;
        write_address_in = rd;
    endtask

    task automatic set_idle();
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    endtask

    // Called at a negedge with the op already applied; returns at the negedge
    // of the first cycle with busywait low. Memory is busy for 'waits'
    // ACCESS cycles, then ready.
    task automatic do_access(input int waits);
        int k;
        k = 0;
        bw_cycles = 0;
        strobe_cycles = 0;
        #1;
        while (busywait && k < 50) begin
            bw_cycles++;
            @(negedge clk);
            k++;
            mem_busywait = (k <= waits);
            #1;
            if (mem_read || mem_write) strobe_cycles++;
            if (k == 1) begin
                cap_addr = {2'b00, mem_address};
                cap_be   = mem_byteenable;
                cap_wd   = mem_writedata;
                cap_rd   = mem_read;
                cap_wr   = mem_write;
            end
        end
        end_tf = timeout_fault;
        end_mf = misalign_fault;
        check("access_bound", 32'(k < 50), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        mem_busywait = 1'b0;
        mem_readdata = 32'h0;
        set_idle();
        repeat (2) @(negedge clk);
        #1;
        check("rst_busywait", 32'(busywait), 32'd0);
        check("rst_wb_en", 32'(wb_write_en), 32'd0);
        check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        reset = 1'b0;

        // ALU op
        @(negedge clk);
        set_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd5);
        #1;
        check("alu_busywait", 32'(busywait), 32'd0);
        @(negedge clk);
        set_idle();
        check("alu_wb_data", wb_data, 32'h1234);
        check("alu_wb_en", 32'(wb_write_en), 32'd1);
        check("alu_wb_addr", 32'(wb_address), 32'd5);

        // LB at 0x103, two wait cycles
        mem_readdata = 32'h80FF_FFFF;
        set_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 1'b1, 5'd9);
        do_access(2);
        set_idle();
        check("lb_mem_addr", cap_addr, 32'h40);
        check("lb_read", 32'(cap_rd), 32'd1);
        check("lb_busy_cycles", 32'(bw_cycles), 32'd4);
        check("lb_strobe_cycles", 32'(strobe_cycles), 32'd3);
        @(negedge clk);
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check("lb_wb_en", 32'(wb_write_en), 32'd1);
        check("lb_wb_addr", 32'(wb_address), 32'd9);

        // Same access as LBU
        set_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 1'b1, 5'd9);
        do_access(2);
        set_idle();
        @(negedge clk);
        check("lbu_wb_data", wb_data, 32'h0000_0080);

        // LH / LHU at 0x102, zero-wait
        set_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 1'b1, 5'd3);
        do_access(0);
        set_idle();
        check("lh_busy_cycles", 32'(bw_cycles), 32'd2);
        @(negedge clk);
        check("lh_wb_data", wb_data, 32'hFFFF_80FF);
        set_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1'b1, 1'b1, 5'd3);
        do_access(0);
        set_idle();
        @(negedge clk);
        check("lhu_wb_data", wb_data, 32'h0000_80FF);

        // LW at 0x100; both strobes requested -> read wins
        mem_readdata = 32'hCAFE_F00D;
        set_op(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 5'd4);
        do_access(1);
        set_idle();
        check("lw_rw_write", 32'(cap_wr), 32'd0);
        @(negedge clk);
        check("lw_wb_data", wb_data, 32'hCAFE_F00D);

        // SH at 0x102
        set_op(1'b0, 1'b1, 3'b001, 32'h102, 32'hAAAA_BEEF, 1'b0, 1'b0, 5'd0);
        do_access(1);
        set_idle();
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wd, 32'hBEEF_BEEF);
        check("sh_write", 32'(cap_wr), 32'd1);
        check("sh_strobe_cycles", 32'(strobe_cycles), 32'd2);
        @(negedge clk);
        check("sh_wb_en", 32'(wb_write_en), 32'd0);

        // SB at 0x101
        set_op(1'b0, 1'b1, 3'b000, 32'h101, 32'h1234_5678, 1'b0, 1'b0, 5'd0);
        do_access(0);
        set_idle();
        check("sb_be", 32'(cap_be), 32'h2);
        check("sb_wdata", cap_wd, 32'h7878_7878);

        // Misaligned LW at 0x101
        @(negedge clk);
        set_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 1'b1, 5'd6);
        do_access(0);
        check("mis_fault", 32'(end_mf), 32'd1);
        check("mis_busy_cycles", 32'(bw_cycles), 32'd0);
        set_idle();
        @(negedge clk);
        #1;
        check("mis_wb_en", 32'(wb_write_en), 32'd0);
        check("mis_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        check("mis_fault_clear", 32'(misalign_fault), 32'd0);

        // Illegal fun_3 value
        set_op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 1'b1, 5'd6);
        #1;
        check("illegal_f3_fault", 32'(misalign_fault), 32'd1);
        @(negedge clk);
        set_idle();

        // Timeout with memory stuck busy
        set_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 1'b1, 5'd8);
        do_access(1000);
        set_idle();
        check("to_strobe_cycles", 32'(strobe_cycles), 32'd4);
        check("to_fault", 32'(end_tf), 32'd1);
        check("to_busy_cycles", 32'(bw_cycles), 32'd4);
        mem_busywait = 1'b0;
        @(negedge clk);
        #1;
        check("to_fault_clear", 32'(timeout_fault), 32'd0);
        check("to_wb_en", 32'(wb_write_en), 32'd0);
        check("to_strobe_low", 32'(mem_read), 32'd0);
        check("to_idle_busy", 32'(busywait), 32'd0);

        // Reset during the 2nd ACCESS cycle of an SW
        set_op(1'b0, 1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0);
        mem_busywait = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_sw_write_pre", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_sw_busywait", 32'(busywait), 32'd0);
        @(negedge clk);
        check("rst_sw_write", 32'(mem_write), 32'd0);
        check("rst_sw_addr", {2'b00, mem_address}, 32'd0);
        check("rst_sw_be_wd", {mem_writedata[27:0], mem_byteenable}, 32'd0);
        check("rst_sw_wb_en", 32'(wb_write_en), 32'd0);
        reset = 1'b0;
        mem_busywait = 1'b0;
        set_op(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 1'b0, 1'b1, 5'd7);
        #1;
        check("post_rst_busy", 32'(busywait), 32'd0);
        @(negedge clk);
        set_idle();
        check("post_rst_wb_data", wb_data, 32'h55);
        check("post_rst_wb_addr", 32'(wb_address), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
